my_processing_system_top: RTL and testbench

MY_PROCESSING_SYSTEM_TOP -- requirements
Module: my_Peocessing_System_top

---
 rtl/my_processing_system_top.sv | 149 ++++++++++++++
 tb/tb_my_processing_system_top.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/my_processing_system_top.sv
// ---------------------------------------------------------------------------
// my_processing_system_top
//   Small button-driven accumulator with an automatic increment and a
//   two-digit hex display.
//
//   The block holds an 8-bit accumulator R and a carry flag C. Four push
//   buttons act on R:
//     - btn[3] clear
//     - btn[0] increment
//     - btn[1] decrement
//     - btn[2] rotate left
//   The buttons are synchronised and edge-detected, so each press is one
//   action. A free-running prescaler triggers an increment every AUTO_DIV
//   cycles. That increment is skipped when a button action falls in the
//   same cycle.
//
// Parameters
//   AUTO_DIV  auto-step period in clock cycles (2..65535)
//
// Ports
//   Clk    in   system clock, rising-edge active
//   Reset  in   asynchronous, active-high reset
//   btn    in   [3:0] asynchronous push-buttons, active high
//   led    out  [1:0] {carry C, zero flag (R==0)}
//   Lseg1  out  [7:0] active-low 7-segment pattern for R[7:4], {dp,g..a}
//   Lseg2  out  [7:0] active-low 7-segment pattern for R[3:0], {dp,g..a}
// ---------------------------------------------------------------------------
module my_processing_system_top #(
  parameter int AUTO_DIV = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] btn,
  output logic [1:0] led,
  output logic [7:0] Lseg1,
  output logic [7:0] Lseg2
);

  localparam logic [15:0] TERM_CNT = 16'(AUTO_DIV - 1);

  // Active-low hex decode; segment order {dp,g,f,e,d,c,b,a}, dp held off.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0:    seg = 8'hC0;
      4'h1:    seg = 8'hF9;
      4'h2:    seg = 8'hA4;
      4'h3:    seg = 8'hB0;
      4'h4:    seg = 8'h99;
      4'h5:    seg = 8'h92;
      4'h6:    seg = 8'h82;
      4'h7:    seg = 8'hF8;
      4'h8:    seg = 8'h80;
      4'h9:    seg = 8'h90;
      4'hA:    seg = 8'h88;
      4'hB:    seg = 8'h83;
      4'hC:    seg = 8'hC6;
      4'hD:    seg = 8'hA1;
      4'hE:    seg = 8'h86;
      4'hF:    seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

  logic [3:0]  sync1_r;
  logic [3:0]  sync2_r;
  logic [3:0]  prev_r;
  logic [7:0]  acc_r;
  logic        carry_r;
  logic [15:0] presc_r;

  logic [3:0]  pulse_s;
  logic        term_s;
  logic [7:0]  acc_nxt_s;
  logic        carry_nxt_s;

  // Rising-edge detect on the synchronised buttons; prev_r starts at 0, so a
  // button already held at reset release still yields one pulse.
  assign pulse_s = sync2_r & ~prev_r;
  assign term_s  = (presc_r == TERM_CNT);

  // Next accumulator/carry: clear > inc > dec > rotate, auto-inc only when
  // no button pulse is present this cycle.
  always_comb begin
    acc_nxt_s   = acc_r;
    carry_nxt_s = carry_r;
    if (pulse_s[3]) begin
      acc_nxt_s   = 8'h00;
      carry_nxt_s = 1'b0;
    end else if (pulse_s[0]) begin
      acc_nxt_s   = acc_r + 8'h01;
      carry_nxt_s = (acc_r == 8'hFF);
    end else if (pulse_s[1]) begin
      acc_nxt_s   = acc_r - 8'h01;
      carry_nxt_s = (acc_r == 8'h00);
    end else if (pulse_s[2]) begin
      acc_nxt_s   = {acc_r[6:0], acc_r[7]};
      carry_nxt_s = acc_r[7];
    end else if (term_s) begin
      acc_nxt_s   = acc_r + 8'h01;
      carry_nxt_s = (acc_r == 8'hFF);
    end else begin
      acc_nxt_s   = acc_r;
      carry_nxt_s = carry_r;
    end
  end

  // Button synchronisers and edge-detect history.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_r <= 4'h0;
      sync2_r <= 4'h0;
      prev_r  <= 4'h0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Free-running prescaler, wraps at AUTO_DIV-1 regardless of buttons.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      presc_r <= 16'h0000;
    end else if (term_s) begin
      presc_r <= 16'h0000;
    end else begin
      presc_r <= presc_r + 16'h0001;
    end
  end

  // Accumulator and carry state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      acc_r   <= 8'h00;
      carry_r <= 1'b0;
    end else begin
      acc_r   <= acc_nxt_s;
      carry_r <= carry_nxt_s;
    end
  end

  // The zero flag and display decode follow R directly, so reset shows at once.
  assign led   = {carry_r, (acc_r == 8'h00)};
  assign Lseg1 = hex_to_seg(acc_r[7:4]);
  assign Lseg2 = hex_to_seg(acc_r[3:0]);

endmodule

// File: tb/tb_my_processing_system_top.sv
module tb_my_processing_system_top;

  localparam int AD = 16;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [3:0] btn;
  logic [1:0] led;
  logic [7:0] Lseg1;
  logic [7:0] Lseg2;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: value/flag, edge index since reset release, and the
  // history of button samples taken at each edge.
  logic [7:0] r_m;
  logic       c_m;
  int         k_m;
  logic [3:0] hist[$];

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  always #5 Clk = ~Clk;

  my_processing_system_top #(.AUTO_DIV(AD)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .btn   (btn),
    .led   (led),
    .Lseg1 (Lseg1),
    .Lseg2 (Lseg2)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".led"},   {14'h0, led},  {14'h0, c_m, (r_m == 8'h00)});
    check({tag, ".Lseg1"}, {8'h0, Lseg1}, {8'h0, seg_tab[r_m[7:4]]});
    check({tag, ".Lseg2"}, {8'h0, Lseg2}, {8'h0, seg_tab[r_m[3:0]]});
  endtask

  // One clock with buttons b, model update, then sample 1 time unit later.
  task automatic tick(input logic [3:0] b, input string tag);
    logic [3:0] s2;
    logic [3:0] s3;
    logic [3:0] p;
    btn = b;
    @(posedge Clk);
    k_m++;
    hist.push_back(b);
    if (hist.size() > 8) void'(hist.pop_front());
    // A press counts once: seen two edges ago but not three edges ago.
    s2 = (hist.size() >= 3) ? hist[hist.size()-3] : 4'h0;
    s3 = (hist.size() >= 4) ? hist[hist.size()-4] : 4'h0;
    p  = s2 & ~s3;
    if (p[3]) begin
      r_m = 8'h00; c_m = 1'b0;
    end else if (p[0]) begin
      c_m = (r_m == 8'hFF); r_m = r_m + 8'h01;
    end else if (p[1]) begin
      c_m = (r_m == 8'h00); r_m = r_m - 8'h01;
    end else if (p[2]) begin
      c_m = r_m[7]; r_m = {r_m[6:0], r_m[7]};
    end else if ((k_m % AD) == 0) begin
      c_m = (r_m == 8'hFF); r_m = r_m + 8'h01;
    end
    #1;
    check_model(tag);
  endtask

  // Asynchronous reset pulse placed between edges; outputs must react at once.
  task automatic pulse_reset(input string tag);
    #2 Reset = 1'b1;
    #1;
    check({tag, ".rst_led"}, {14'h0, led},  16'h0001);
    check({tag, ".rst_s1"},  {8'h0, Lseg1}, 16'h00C0);
    check({tag, ".rst_s2"},  {8'h0, Lseg2}, 16'h00C0);
    r_m = 8'h00; c_m = 1'b0; k_m = 0; hist.delete();
    repeat (2) @(posedge Clk);
    #1;
    check({tag, ".hold_led"}, {14'h0, led}, 16'h0001);
    #2 Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    btn   = 4'h0;
    r_m = 8'h00; c_m = 1'b0; k_m = 0;
    #12;
    check("init.led", {14'h0, led},  16'h0001);
    check("init.s1",  {8'h0, Lseg1}, 16'h00C0);
    check("init.s2",  {8'h0, Lseg2}, 16'h00C0);
    #1 Reset = 1'b0;

    // Auto stepping from reset release.
    repeat (16) tick(4'h0, "auto16");
    check("auto16.s2",  {8'h0, Lseg2}, 16'h00F9);
    check("auto16.led", {14'h0, led},  16'h0000);
    repeat (16) tick(4'h0, "auto32");
    check("auto32.s2",  {8'h0, Lseg2}, 16'h00A4);

    // Reach R=0x37 (55 auto steps in total), then reset asynchronously.
    repeat (55 * AD - 32) tick(4'h0, "to37");
    check("r37.s1", {8'h0, Lseg1}, 16'h00B0);
    check("r37.s2", {8'h0, Lseg2}, 16'h00F8);
    pulse_reset("r37");

    // Held decrement from 0: exactly one step to 0xFF.
    repeat (10) tick(4'b0010, "dec_hold");
    check("dec.s1",  {8'h0, Lseg1}, 16'h008E);
    check("dec.s2",  {8'h0, Lseg2}, 16'h008E);
    check("dec.led", {14'h0, led},  16'h0002);
    repeat (6) tick(4'h0, "wrap_auto");
    check("wrap.led", {14'h0, led},  16'h0003);
    tick(4'b0001, "inc_a"); tick(4'b0001, "inc_b"); tick(4'h0, "inc_c");
    check("inc.s2",  {8'h0, Lseg2}, 16'h00F9);
    check("inc.led", {14'h0, led},  16'h0000);

    // R=0x81 via 129 auto steps, then rotate left.
    pulse_reset("r81a");
    repeat (129 * AD) tick(4'h0, "to81a");
    check("r81.s1", {8'h0, Lseg1}, 16'h0080);
    check("r81.s2", {8'h0, Lseg2}, 16'h00F9);
    tick(4'b0100, "rot_a"); tick(4'b0100, "rot_b"); tick(4'h0, "rot_c");
    check("rot.led", {14'h0, led},  16'h0002);
    check("rot.s1",  {8'h0, Lseg1}, 16'h00C0);
    check("rot.s2",  {8'h0, Lseg2}, 16'h00B0);

    // R=0x81 again, then increment and clear together: clear wins.
    pulse_reset("r81b");
    repeat (129 * AD) tick(4'h0, "to81b");
    tick(4'b1001, "clr_a"); tick(4'b1001, "clr_b"); tick(4'h0, "clr_c");
    check("clr.led", {14'h0, led},  16'h0001);
    check("clr.s1",  {8'h0, Lseg1}, 16'h00C0);
    check("clr.s2",  {8'h0, Lseg2}, 16'h00C0);

    // Increment pulse landing exactly on a terminal count: +1 only.
    while ((k_m % AD) != AD - 3) tick(4'h0, "align");
    tick(4'b0001, "coin_a"); tick(4'b0001, "coin_b");
    check("coin.pre_s2", {8'h0, Lseg2}, 16'h00C0);
    tick(4'b0001, "coin_c");
    check("coin.s2", {8'h0, Lseg2}, 16'h00F9);
    repeat (5) tick(4'h0, "coin_after");
    check("coin.after_s2", {8'h0, Lseg2}, 16'h00F9);

    // Randomised button activity with a reset landing on a pending press.
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] b;
      b = btn;
      if ($urandom_range(3, 0) == 0) b = 4'($urandom_range(15, 0));
      if (i == 700) begin
        tick(4'h0, "rnd_pre");
        tick(4'b0001, "rnd_rise");
        btn = 4'b0101;
        pulse_reset("rnd_rst");
      end else begin
        tick(b, "rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
